traffic_sched: RTL and testbench
================================

# traffic_sched

Time-of-day and request scheduler for the highway/country traffic light controller.
- Keeps the wall-clock hours and minutes that the light controller consumes, and decides day or night mode.
- Arbitrates two requesters for the country-road green phase: the country-road car sensor X and the keyed request B/char.
- Issues one grant at a time to the light controller through a grant/done handshake.

## Interface
- TICKS_PER_MIN, default 60: clock cycles per minute. Must be ≥ 2.
- HOLDOFF_CYCLES, default 4: idle cycles forced after each grant ends.
- MAX_GRANT, default 32: grant cycles before a forced release.
- clock  in  1  system clock; all logic is on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- load  in  1  load the time from set_hours and set_minutes.
- set_hours  in  5  value loaded into hours.
- set_minutes  in  6  value loaded into minutes.
- X  in  1  car present on the country road (level).
- B  in  1  keyed-request strobe; char is valid while B=1.
- char  in  8  ASCII key code.
- done  in  1  light controller has finished the granted phase.
- hours  out  5  current hour, 0–23.
- minutes  out  6  current minute, 0–59.
- night  out  1  high when the time is ≥ 21:01 or < 05:00.
- grant  out  1  country phase granted.
- grant_src  out  1  source of the grant: 0 = car, 1 = key.
- key_reject  out  1  one-cycle pulse for an invalid key.
- load_err  out  1  one-cycle pulse for an out-of-range load.
- timeout  out  1  one-cycle pulse on a forced release.

## Operation

**Reset values** (after any clock edge with clear=1, from any state):
- hours=0, minutes=0, night=1.
- grant=0, grant_src=0.
- All pulse outputs 0.
- Prescaler 0, key_pend=0, last_src=1 (key), FSM in IDLE.

**Timekeeping**
- The prescaler counts 0 .. TICKS_PER_MIN-1.
- At the terminal count it wraps to 0 and minutes increments.
- 59 minutes wraps to 0 and hours increments; 23:59 wraps to 00:00.
- A load with set_hours ≤ 23 and set_minutes ≤ 59 writes both fields and zeroes the prescaler. Load has priority over the tick in the same cycle.
- A load with either field out of range leaves the time unchanged and pulses load_err.
- night is decoded combinationally from the hours and minutes registers.

**Request qualification**
- Valid key: B=1 and char ∈ {0x61, 0x62, 0x63}. This sets the sticky flag key_pend.
- B=1 with any other char pulses key_reject on the next cycle; key_pend is unchanged.
- Car request: X=1 and night=0. X is ignored at night and is never latched.
- key_pend clears only when a key grant is issued.
- A key strobe arriving while a grant is active or during holdoff is latched and served later.

**FSM: IDLE → GRANT → HOLDOFF → IDLE**
- IDLE:
  - If any request is pending, move to GRANT and assert grant with grant_src set to the winner.
  - On a tie, the winner is the source opposite last_src.
  - The winner is written into last_src.
- GRANT:
  - grant stays high. grant_src is stable.
  - On done=1, or when the grant counter reaches MAX_GRANT, drop grant and go to HOLDOFF.
  - A forced release also pulses timeout.
  - done in the same cycle as the MAX_GRANT limit counts as done: no timeout pulse.
- HOLDOFF:
  - Count HOLDOFF_CYCLES cycles, then return to IDLE.
  - done is ignored in this state.
- A day/night change while in GRANT does not abort the grant.

## Timing
- Request sampled at edge N → grant=1 after edge N+1.
- done sampled at edge M → grant=0 after edge M.
- The earliest next grant is HOLDOFF_CYCLES+1 edges after grant falls.
- A grant lasts 1 to MAX_GRANT cycles.
- key_reject, load_err and timeout are each exactly one cycle wide, registered, and appear one edge after the cause.
- The minute advances exactly every TICKS_PER_MIN cycles when no load occurs.
- clear asserted mid-grant → grant=0 after that edge. Pending key requests are lost.

## Test plan
- **Reset and time wrap.** Hold clear 3 cycles, then load 23:59 and run TICKS_PER_MIN cycles. Required: 00:00, night=1. Then load 24:00. Required: load_err pulse, time unchanged.
- **Day car request.** Load 05:00, set X=1, answer done 5 cycles into the grant. Required: grant one edge after X, grant_src=0, held 5 cycles, then 4 idle cycles before the next grant.
- **Night filtering.** Load 21:01, set X=1. Required: no grant. Then B=1, char=0x61 for one cycle. Required: grant with grant_src=1. Then char=0x64. Required: key_reject pulse, no grant.
- **Tie arbitration.** Load 12:00. Present X=1 and a valid key in the same cycle. Required: car first (last_src resets to key), then key after holdoff. With both pending again, car wins next.
- **Timeout and a done collision.** Never assert done. Required: grant drops after 32 cycles with a timeout pulse. Then assert done exactly on cycle 32. Required: no timeout pulse.
- **Clear mid-operation.** Key pending, grant active. Assert clear. Required: grant=0, 00:00, and no grant after clear falls until a new request arrives.

Source files
------------

// File: rtl/traffic_sched.sv
// traffic_sched
//   Time-of-day keeper and country-phase request scheduler for the
//   highway/country traffic light controller.
//
//   Timekeeping: an up-counting prescaler divides clock into minutes. The
//   hours:minutes registers wrap at 23:59. A valid load replaces the time
//   and restarts the minute. night is decoded from the time registers.
//
//   Requests: X (car, day only) and a keyed strobe B/char (a, b or c). Both
//   are registered before arbitration. A key is held in key_pend until it is
//   granted. The two sources alternate on a tie, using last_src.
//
// Ports
//   clock, clear              rising-edge clock, synchronous active-high reset
//   load, set_hours/minutes   time load request and value
//   X                         car present on the country road (level)
//   B, char                   key strobe and its ASCII code
//   done                      light controller finished the granted phase
//   hours, minutes, night     current time and day/night decode
//   grant, grant_src          country phase granted, source (0 car, 1 key)
//   key_reject, load_err      one-cycle pulses for an invalid key or load
//   timeout                   one-cycle pulse when a grant is forced off
//
// FSM states
//   state   | meaning
//   IDLE    | no grant; waiting for a registered request
//   GRANT   | grant high; waiting for done or the MAX_GRANT limit
//   HOLDOFF | grant low for HOLDOFF_CYCLES cycles; requests still latch
module traffic_sched #(
  parameter int TICKS_PER_MIN  = 60,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int MAX_GRANT      = 32
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       X,
  input  logic       B,
  input  logic [7:0] char,
  input  logic       done,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic       night,
  output logic       grant,
  output logic       grant_src,
  output logic       key_reject,
  output logic       load_err,
  output logic       timeout
);

  localparam int PW = $clog2(TICKS_PER_MIN);
  localparam int GW = $clog2(MAX_GRANT + 1);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          src_q, src_d;
  logic          last_q, last_d;
  logic          timeout_d;
  logic          take_key;
  logic          win;
  logic          car_q;
  logic          key_pend;
  logic          load_ok;
  logic          key_ok;

  // ---------------------------------------------------------------- time
  assign load_ok = (set_hours <= 5'd23) && (set_minutes <= 6'd59);

  always_ff @(posedge clock) begin
    if (clear) begin
      presc    <= '0;
      hours    <= '0;
      minutes  <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load && !load_ok;
      if (load && load_ok) begin
        hours   <= set_hours;
        minutes <= set_minutes;
        presc   <= '0;
      end else if (presc == PW'(TICKS_PER_MIN - 1)) begin
        presc <= '0;
        if (minutes == 6'd59) begin
          minutes <= '0;
          hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Night covers 21:01 through 04:59.
  assign night = (hours < 5'd5) || (hours > 5'd21) ||
                 ((hours == 5'd21) && (minutes != 6'd0));

  // ------------------------------------------------------------ requests
  assign key_ok = B && ((char == 8'h61) || (char == 8'h62) || (char == 8'h63));

  // car_q is a one-cycle sample of the qualified car level, not a sticky
  // flag: dropping X (or nightfall) withdraws the request.
  always_ff @(posedge clock) begin
    if (clear) begin
      car_q      <= 1'b0;
      key_pend   <= 1'b0;
      key_reject <= 1'b0;
    end else begin
      car_q      <= X && !night;
      key_pend   <= (key_pend && !take_key) || key_ok;
      key_reject <= B && !key_ok;
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      hcnt_q  <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      hcnt_q  <= hcnt_d;
      src_q   <= src_d;
      last_q  <= last_d;
      timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    hcnt_d    = hcnt_q;
    src_d     = src_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    take_key  = 1'b0;
    win       = 1'b0;
    case (state_q)
      IDLE: begin
        if (car_q || key_pend) begin
          // On a tie the source that did not win last time goes first.
          win      = (car_q && key_pend) ? !last_q : key_pend;
          state_d  = GRANT;
          src_d    = win;
          last_d   = win;
          gcnt_d   = GW'(1);
          take_key = win;
        end
      end
      GRANT: begin
        if (done || (gcnt_q == GW'(MAX_GRANT))) begin
          // done on the limit cycle is a normal finish, not a timeout.
          timeout_d = !done;
          state_d   = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          hcnt_d    = '0;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      HOLDOFF: begin
        if (hcnt_q == HW'(HOLDOFF_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant     = (state_q == GRANT);
  assign grant_src = src_q;

endmodule

// File: tb/tb_traffic_sched.sv
module tb_traffic_sched;

  localparam int T = 60;
  localparam int H = 4;
  localparam int M = 32;

  logic       clock = 1'b0;
  logic       clear;
  logic       load;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       X;
  logic       B;
  logic [7:0] char;
  logic       done;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic       night;
  logic       grant;
  logic       grant_src;
  logic       key_reject;
  logic       load_err;
  logic       timeout;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];
  logic exp_s;

  traffic_sched #(.TICKS_PER_MIN(T), .HOLDOFF_CYCLES(H), .MAX_GRANT(M)) dut (
    .clock(clock), .clear(clear), .load(load), .set_hours(set_hours),
    .set_minutes(set_minutes), .X(X), .B(B), .char(char), .done(done),
    .hours(hours), .minutes(minutes), .night(night), .grant(grant),
    .grant_src(grant_src), .key_reject(key_reject), .load_err(load_err),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_time(input logic [4:0] h, input logic [5:0] m);
    load = 1'b1; set_hours = h; set_minutes = m;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) step();
    total++;
    if ({hours, minutes, night} !== {5'd0, 6'd0, 1'b1}) begin
      bad++; $display("FAIL reset_time got %0d:%0d night=%b want 0:0 night=1", hours, minutes, night);
    end
    total++;
    if ({grant, grant_src, key_reject, load_err, timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_outs got g=%b s=%b kr=%b le=%b to=%b want all 0",
                      grant, grant_src, key_reject, load_err, timeout);
    end
    clear = 1'b0;
    load_time(5'd23, 6'd59);
    total++;
    if ({hours, minutes, night} !== {5'd23, 6'd59, 1'b1}) begin
      bad++; $display("FAIL load_2359 got %0d:%0d night=%b want 23:59 night=1", hours, minutes, night);
    end
    repeat (T - 1) step();
    total++;
    if ({hours, minutes} !== {5'd23, 6'd59}) begin
      bad++; $display("FAIL pre_wrap got %0d:%0d want 23:59", hours, minutes);
    end
    step();
    total++;
    if ({hours, minutes, night} !== {5'd0, 6'd0, 1'b1}) begin
      bad++; $display("FAIL day_wrap got %0d:%0d night=%b want 0:0 night=1", hours, minutes, night);
    end
    load_time(5'd24, 6'd0);
    total++;
    if ({load_err, hours, minutes} !== {1'b1, 5'd0, 6'd0}) begin
      bad++; $display("FAIL bad_load got le=%b %0d:%0d want le=1 0:0", load_err, hours, minutes);
    end
    step();
    total++;
    if ({load_err, hours, minutes} !== {1'b0, 5'd0, 6'd0}) begin
      bad++; $display("FAIL bad_load_pulse got le=%b %0d:%0d want le=0 0:0", load_err, hours, minutes);
    end
  endtask

  task automatic test_day_car();
    int n;
    load_time(5'd5, 6'd0);
    total++;
    if (night !== 1'b0) begin
      bad++; $display("FAIL day_0500 got night=%b want 0", night);
    end
    X = 1'b1;
    step();
    total++;
    if (grant !== 1'b0) begin
      bad++; $display("FAIL car_latency got grant=%b want 0 after first edge", grant);
    end
    exp_q.push_back(1'b0);
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL car_grant got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    n = 1;
    repeat (4) begin step(); if (grant) n++; end
    done = 1'b1;
    step();
    done = 1'b0;
    total++;
    if (n !== 5 || grant !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL car_hold got cycles=%0d g=%b to=%b want 5 0 0", n, grant, timeout);
    end
    n = 0;
    repeat (H) begin step(); if (grant) n++; end
    exp_q.push_back(1'b0);
    step();
    total++; exp_s = exp_q.pop_front();
    if (n !== 0 || grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL car_holdoff got early=%0d g=%b s=%b want 0 1 %b", n, grant, grant_src, exp_s);
    end
    X = 1'b0; done = 1'b1;
    step();
    done = 1'b0;
    repeat (H) step();
  endtask

  task automatic test_night();
    int n;
    load_time(5'd21, 6'd1);
    total++;
    if (night !== 1'b1) begin
      bad++; $display("FAIL night_2101 got night=%b want 1", night);
    end
    X = 1'b1;
    n = 0;
    repeat (6) begin step(); if (grant) n++; end
    X = 1'b0;
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL night_car got grant_cycles=%0d want 0", n);
    end
    B = 1'b1; char = 8'h61;
    step();
    B = 1'b0; char = 8'h00;
    exp_q.push_back(1'b1);
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL night_key got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (H) step();
    B = 1'b1; char = 8'h64;
    step();
    B = 1'b0; char = 8'h00;
    total++;
    if (key_reject !== 1'b1) begin
      bad++; $display("FAIL key_reject got %b want 1", key_reject);
    end
    step();
    total++;
    if (key_reject !== 1'b0) begin
      bad++; $display("FAIL key_reject_width got %b want 0", key_reject);
    end
    n = 0;
    repeat (6) begin step(); if (grant) n++; end
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL reject_no_grant got grant_cycles=%0d want 0", n);
    end
  endtask

  task automatic test_tie();
    int n;
    load_time(5'd12, 6'd0);
    X = 1'b1; B = 1'b1; char = 8'h62;
    step();
    B = 1'b0; char = 8'h00;
    exp_q.push_back(1'b0);
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL tie_first got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    done = 1'b1; step(); done = 1'b0;
    exp_q.push_back(1'b1);
    n = 0;
    repeat (H) begin step(); if (grant) n++; end
    step();
    total++; exp_s = exp_q.pop_front();
    if (n !== 0 || grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL tie_second got early=%0d g=%b s=%b want 0 1 %b", n, grant, grant_src, exp_s);
    end
    B = 1'b1; char = 8'h63;
    step();
    B = 1'b0; char = 8'h00;
    total++;
    if (grant !== 1'b1 || grant_src !== 1'b1) begin
      bad++; $display("FAIL src_stable got g=%b s=%b want 1 1", grant, grant_src);
    end
    done = 1'b1; step(); done = 1'b0;
    exp_q.push_back(1'b0);
    repeat (H) step();
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL tie_third got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    X = 1'b0; done = 1'b1; step(); done = 1'b0;
    exp_q.push_back(1'b1);
    repeat (H) step();
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL late_key got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    done = 1'b1; step(); done = 1'b0;
    repeat (H) step();
  endtask

  task automatic test_timeout();
    int n;
    load_time(5'd12, 6'd0);
    X = 1'b1; step(); X = 1'b0;
    exp_q.push_back(1'b0);
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL to_grant got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    n = 1;
    for (int i = 0; i < M + 8 && grant; i++) begin
      step();
      if (grant) n++;
    end
    total++;
    if (n !== M || grant !== 1'b0 || timeout !== 1'b1) begin
      bad++; $display("FAIL timeout got cycles=%0d g=%b to=%b want %0d 0 1", n, grant, timeout, M);
    end
    step();
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("FAIL timeout_width got %b want 0", timeout);
    end
    repeat (H - 1) step();
    X = 1'b1; step(); X = 1'b0;
    step();
    repeat (M - 1) step();
    total++;
    if (grant !== 1'b1) begin
      bad++; $display("FAIL at_limit got grant=%b want 1", grant);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    total++;
    if (grant !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL done_collision got g=%b to=%b want 0 0", grant, timeout);
    end
    repeat (H) step();
  endtask

  task automatic test_clear();
    int n;
    load_time(5'd12, 6'd0);
    B = 1'b1; char = 8'h61; step(); B = 1'b0;
    exp_q.push_back(1'b1);
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL clr_pre got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    B = 1'b1; char = 8'h62; step(); B = 1'b0; char = 8'h00;
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++;
    if ({grant, grant_src, hours, minutes} !== {1'b0, 1'b0, 5'd0, 6'd0}) begin
      bad++; $display("FAIL clr_mid got g=%b s=%b %0d:%0d want 0 0 0:0", grant, grant_src, hours, minutes);
    end
    n = 0;
    repeat (10) begin step(); if (grant) n++; end
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL clr_lost got grant_cycles=%0d want 0", n);
    end
    B = 1'b1; char = 8'h63; step(); B = 1'b0; char = 8'h00;
    exp_q.push_back(1'b1);
    step();
    total++; exp_s = exp_q.pop_front();
    if (grant !== 1'b1 || grant_src !== exp_s) begin
      bad++; $display("FAIL clr_new got g=%b s=%b want g=1 s=%b", grant, grant_src, exp_s);
    end
    done = 1'b1; step(); done = 1'b0;
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; set_hours = '0; set_minutes = '0;
    X = 1'b0; B = 1'b0; char = '0; done = 1'b0;
    test_reset();
    test_day_car();
    test_night();
    test_tie();
    test_timeout();
    test_clear();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
